// File: rtl/bip_control.sv
// bip_control: control unit of the BIP accumulator processor.
// Holds the program counter, the IDLE/RUN/HALT state machine and the
// executed-cycle counter, and decodes the 16-bit instruction word into the
// datapath selects (accumulator mux, ALU B mux, ALU add/subtract) and the
// accumulator / data-memory strobes.
module bip_control #(
  parameter int PC_W  = 11,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic [15:0]      instr,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  operand,
  output logic [1:0]       sel_a,
  output logic             sel_b,
  output logic             op,
  output logic             wr_acc,
  output logic             rd_ram,
  output logic             wr_ram,
  output logic             halted,
  output logic             running,
  output logic [CNT_W-1:0] cycles
);

  // Run/halt state machine encoding.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

  // Opcode field values; 01000..11111 are all NOPs and fall to the default arm.
  typedef enum logic [4:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111
  } opcode_e;

  // Accumulator source select encodings.
  localparam logic [1:0] SEL_A_RAM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  // ALU B source select encodings.
  localparam logic SEL_B_RAM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  // ALU operation encodings.
  localparam logic ALU_SUB = 1'b0;
  localparam logic ALU_ADD = 1'b1;

  localparam logic [CNT_W-1:0] CYCLES_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  opcode_e opcode;
  logic    is_hlt;
  logic    exec;

  // Strobe requests from the decoder, before gating with the execute cycle.
  logic    dec_wr_acc;
  logic    dec_rd_ram;
  logic    dec_wr_ram;

  assign opcode  = opcode_e'(instr[15:11]);
  assign is_hlt  = (opcode == OP_HLT);
  assign operand = instr[PC_W-1:0];

  // An execute cycle is RUN with the step enable high. The reset cycle is
  // excluded so a synchronous reset mid-program never fires a strobe.
  assign exec = (state_q == S_RUN) && enable && !reset;

  // State register: synchronous reset to IDLE.
  // NOTE: every clocked assignment uses <= so all flops sample the values
  // from before the edge; a blocking = here would let later statements see
  // the new value and break the register model.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start leaves IDLE, an executed HLT enters HALT,
  // HALT is only left through reset.
  // NOTE: the hold value is assigned first so every path through the
  // case leaves state_d driven; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (enable && is_hlt) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: status flags from the state, strobes gated to execute cycles.
  always_comb begin
    running = (state_q == S_RUN);
    halted  = (state_q == S_HALT);
    wr_acc  = exec && dec_wr_acc;
    rd_ram  = exec && dec_rd_ram;
    wr_ram  = exec && dec_wr_ram;
  end

  // Instruction decode: datapath selects follow instr in every state; the
  // strobe requests are qualified by the output logic above.
  always_comb begin
    sel_a      = SEL_A_RAM;
    sel_b      = SEL_B_RAM;
    op         = ALU_ADD;
    dec_wr_acc = 1'b0;
    dec_rd_ram = 1'b0;
    dec_wr_ram = 1'b0;
    case (opcode)
      OP_HLT: begin
        // No strobes; the state machine handles the stop.
      end
      OP_STO: begin
        dec_wr_ram = 1'b1;
      end
      OP_LD: begin
        dec_rd_ram = 1'b1;
        sel_a      = SEL_A_RAM;
        dec_wr_acc = 1'b1;
      end
      OP_LDI: begin
        sel_a      = SEL_A_IMM;
        dec_wr_acc = 1'b1;
      end
      OP_ADD: begin
        dec_rd_ram = 1'b1;
        sel_b      = SEL_B_RAM;
        op         = ALU_ADD;
        sel_a      = SEL_A_ALU;
        dec_wr_acc = 1'b1;
      end
      OP_ADDI: begin
        sel_b      = SEL_B_IMM;
        op         = ALU_ADD;
        sel_a      = SEL_A_ALU;
        dec_wr_acc = 1'b1;
      end
      OP_SUB: begin
        dec_rd_ram = 1'b1;
        sel_b      = SEL_B_RAM;
        op         = ALU_SUB;
        sel_a      = SEL_A_ALU;
        dec_wr_acc = 1'b1;
      end
      OP_SUBI: begin
        sel_b      = SEL_B_IMM;
        op         = ALU_SUB;
        sel_a      = SEL_A_ALU;
        dec_wr_acc = 1'b1;
      end
      default: begin
        // NOP range: defaults already applied, PC still advances.
      end
    endcase
  end

  // Program counter and cycle counter next values. The PC stays on an HLT
  // so the debugger sees the halting address; it wraps silently at the top.
  // The cycle counter includes the HLT cycle and saturates at all-ones.
  always_comb begin
    pc_d     = pc_q;
    cycles_d = cycles_q;
    if (exec) begin
      if (!is_hlt) begin
        pc_d = pc_q + 1'b1;
      end
      if (cycles_q != CYCLES_MAX) begin
        cycles_d = cycles_q + 1'b1;
      end
    end
  end

  // Counter registers: synchronous reset clears both.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      cycles_q <= '0;
    end else begin
      pc_q     <= pc_d;
      cycles_q <= cycles_d;
    end
  end

  assign pc     = pc_q;
  assign cycles = cycles_q;

endmodule
